// File: rtl/core_data_responder.sv
// -----------------------------------------------------------------------------
// core_data_pkg / core_data_responder
//
// Memory-side responder for the cluster core data port. It accepts requests
// from one core and serves them from a local word-addressed scratchpad. Each
// response comes back a fixed Latency cycles after the grant edge. It also
// keeps a saturating count of granted out-of-range accesses for debug.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   data_req_i  request  {req, add[31:0], we, data[31:0], be[3:0]}
//   data_rsp_o  response {gnt, r_data[31:0], r_valid}
//   stall_i     forces gnt low while high (wait-state injection)
//   err_cnt_o   saturating count of granted out-of-range accesses
// -----------------------------------------------------------------------------
package core_data_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;

endpackage

module core_data_responder
  import core_data_pkg::*;
#(
  parameter int unsigned NumWords = 256,
  parameter logic [31:0] BaseAddr = 32'h1000_0000,
  parameter int unsigned Latency  = 1,
  parameter logic [31:0] ErrData  = 32'hDEAD_BEEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  core_data_req_t data_req_i,
  output core_data_rsp_t data_rsp_o,
  input  logic           stall_i,
  output logic [15:0]    err_cnt_o
);

  localparam int unsigned AddrW     = $clog2(4 * NumWords);
  localparam int unsigned IdxW      = AddrW - 2;
  localparam logic [31:0] SpanBytes = 32'(4 * NumWords);

  // ---------------------------------------------------------------------------
  // Handshake and address decode
  // ---------------------------------------------------------------------------
  logic            gnt;
  logic            acc;
  logic [31:0]     off;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic            wr_en;

  assign gnt = data_req_i.req & ~stall_i;
  // A grant seen while reset is held must leave no trace: no response,
  // no count, no memory update.
  assign acc = gnt & rst_ni;

  // Unsigned subtraction wraps addresses below BaseAddr to large offsets,
  // so a single compare covers both ends of the window.
  assign off      = data_req_i.add - BaseAddr;
  assign in_range = (off < SpanBytes);
  assign idx      = off[AddrW-1:2];
  assign wr_en    = acc & data_req_i.we & in_range;

  // ---------------------------------------------------------------------------
  // Scratchpad (not reset; contents survive rst_ni)
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] mem [NumWords];
  logic [31:0]     rd_data;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_req_i.be[b]) mem[idx][b] <= data_req_i.data[8*b +: 8];
      end
    end
  end

  // Read value sampled before this edge's write lands; a write and a read
  // can never share a grant, so there is no same-edge conflict.
  assign rd_data = mem[idx];

  // ---------------------------------------------------------------------------
  // Response pipeline: Latency stages of {valid, data}
  // ---------------------------------------------------------------------------
  logic [Latency-1:0]       vld_d, vld_q;
  logic [Latency-1:0][31:0] dat_d, dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    // Stage 0 loads every edge; data is zero unless this is a granted read,
    // which keeps r_data at 0 whenever r_valid is low.
    vld_d[0] = acc;
    dat_d[0] = '0;
    if (acc && !data_req_i.we) dat_d[0] = in_range ? rd_data : ErrData;
    for (int s = 1; s < Latency; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Out-of-range counter (saturating)
  // ---------------------------------------------------------------------------
  logic [15:0] err_cnt_d, err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (acc && !in_range && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    data_rsp_o         = '0;
    data_rsp_o.gnt     = gnt;
    data_rsp_o.r_valid = vld_q[Latency-1];
    data_rsp_o.r_data  = dat_q[Latency-1];
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_core_data_responder.sv
// -----------------------------------------------------------------------------
// tb_core_data_responder
//
// Drives three responders (Latency 1, 3, 4) from one shared request stream.
// A behavioural model records what each grant must return: a word array for
// the scratchpad, a plain error counter, and a short history of per-edge
// response records. Each responder's output is that history delayed by its
// latency. Directed sequences pin the model with literal values; a randomized
// phase with stalls and out-of-range addresses follows.
// -----------------------------------------------------------------------------
module tb_core_data_responder;
  import core_data_pkg::*;

  localparam int          NW   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           stall = 1'b0;
  core_data_req_t req   = '0;
  core_data_rsp_t rsp1, rsp3, rsp4;
  logic [15:0]    err1, err3, err4;

  always #5 clk = ~clk;

  core_data_responder #(.NumWords(NW), .BaseAddr(BASE), .Latency(1), .ErrData(ERRD)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_rsp_o(rsp1), .stall_i(stall), .err_cnt_o(err1));
  core_data_responder #(.NumWords(NW), .BaseAddr(BASE), .Latency(3), .ErrData(ERRD)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_rsp_o(rsp3), .stall_i(stall), .err_cnt_o(err3));
  core_data_responder #(.NumWords(NW), .BaseAddr(BASE), .Latency(4), .ErrData(ERRD)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_rsp_o(rsp4), .stall_i(stall), .err_cnt_o(err4));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } rec_t;

  rec_t        hist [8];       // response record produced at each edge
  int unsigned e    = 8;       // edge counter (starts high so e-L+1 >= 0)
  logic [31:0] mmem [NW];
  int          merr = 0;

  always @(posedge clk) begin
    rec_t        r;
    logic [31:0] off;
    r = '0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      merr = 0;
    end else if (req.req && !stall) begin
      off = req.add - BASE;
      r.v = 1'b1;
      if (off >= 32'(4 * NW)) begin
        if (merr < 65535) merr++;
        if (!req.we) r.d = ERRD;
      end else if (req.we) begin
        for (int b = 0; b < 4; b++)
          if (req.be[b]) mmem[off >> 2][8*b +: 8] = req.data[8*b +: 8];
      end else begin
        r.d = mmem[off >> 2];
      end
    end
    e++;
    hist[e % 8] = r;
  end

  task automatic chk_dut(input string nm, input int lat, input core_data_rsp_t r,
                         input logic [15:0] ec);
    rec_t x;
    x = rst_n ? hist[(e - 32'(lat) + 1) % 8] : '0;
    chk({nm, ".gnt"},     32'(r.gnt),     32'(req.req & ~stall));
    chk({nm, ".r_valid"}, 32'(r.r_valid), 32'(x.v));
    chk({nm, ".r_data"},  r.r_data,       x.d);
    chk({nm, ".err_cnt"}, 32'(ec),        rst_n ? 32'(merr) : 32'd0);
  endtask

  always @(negedge clk) begin
    chk_dut("l1", 1, rsp1, err1);
    chk_dut("l3", 3, rsp3, err3);
    chk_dut("l4", 4, rsp4, err4);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; returns 1 time unit after its grant edge.
  task automatic put(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    req.req  = 1'b1;
    req.we   = we;
    req.add  = a;
    req.data = d;
    req.be   = be;
    cyc();
    req = '0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int c4;
    int sel;
    rst_n = 1'b0;
    req   = '0;
    stall = 1'b0;
    repeat (3) cyc();
    chk("reset_rvalid", 32'(rsp4.r_valid), 32'd0);
    chk("reset_err", 32'(err1), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Preload every word so no later read sees uninitialized contents.
    for (int i = 0; i < NW; i++) put(1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

    // Basic write/read
    put(1'b1, BASE + 8, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp1.r_valid), 32'd1);
    chk("wr_rsp_data", rsp1.r_data, 32'd0);
    put(1'b0, BASE + 8, 32'd0, 4'h0);
    @(negedge clk);
    chk("rd_cafe", rsp1.r_data, 32'hCAFE_F00D);

    // Byte enables
    put(1'b1, BASE + 12, 32'h1122_3344, 4'hF);
    put(1'b1, BASE + 12, 32'hAABB_CCDD, 4'b0101);
    put(1'b0, BASE + 12, 32'd0, 4'h0);
    @(negedge clk);
    chk("rd_be_merge", rsp1.r_data, 32'h11BB_33DD);
    put(1'b1, BASE + 12, 32'hFFFF_FFFF, 4'h0);
    @(negedge clk);
    chk("be0_valid", 32'(rsp1.r_valid), 32'd1);
    put(1'b0, BASE + 12, 32'd0, 4'h0);
    @(negedge clk);
    chk("be0_unchanged", rsp1.r_data, 32'h11BB_33DD);

    // Streaming: 8 back-to-back reads
    cyc();
    for (int i = 0; i < 8; i++) put(1'b0, BASE + 32'(4 * i), 32'd0, 4'h0);
    repeat (5) cyc();

    // Stall held 5 cycles, then released
    req.req = 1'b1; req.add = BASE + 16; req.we = 1'b0;
    stall = 1'b1;
    repeat (5) cyc();
    stall = 1'b0;
    cyc();
    req = '0;
    repeat (5) cyc();

    // Out of range
    put(1'b0, BASE - 4, 32'd0, 4'h0);
    @(negedge clk);
    chk("oor_low_data", rsp1.r_data, ERRD);
    put(1'b0, BASE + 32'(4 * NW), 32'd0, 4'h0);
    @(negedge clk);
    chk("oor_high_data", rsp1.r_data, ERRD);
    put(1'b1, BASE + 32'(4 * NW), 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("oor_err3", 32'(err1), 32'd3);
    put(1'b0, BASE + 8, 32'd0, 4'h0);
    @(negedge clk);
    chk("oor_mem_intact", rsp1.r_data, 32'hCAFE_F00D);

    // Randomized phase; a stalled request is held unchanged until granted.
    cyc();
    for (int k = 0; k < 3000; k++) begin
      if (!req.req || !stall) begin
        req.req  = ($urandom_range(0, 3) != 0);
        req.we   = 1'($urandom);
        req.data = $urandom;
        req.be   = 4'($urandom);
        sel = $urandom_range(0, 9);
        case (sel)
          0:       req.add = BASE - 32'($urandom_range(1, 64));
          1:       req.add = BASE + 32'(4 * NW) + 32'($urandom_range(0, 255));
          2:       req.add = $urandom;
          default: req.add = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
        endcase
      end
      stall = ($urandom_range(0, 4) == 0);
      cyc();
    end
    req   = '0;
    stall = 1'b0;
    repeat (6) cyc();

    // Reset mid-flight
    put(1'b1, BASE + 20, 32'h5A5A_A5A5, 4'hF);
    repeat (6) cyc();
    put(1'b0, BASE + 8,  32'd0, 4'h0);
    put(1'b0, BASE + 12, 32'd0, 4'h0);
    put(1'b0, BASE + 16, 32'd0, 4'h0);
    rst_n = 1'b0;
    c4 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp4.r_valid) c4++;
      if (i == 1) begin
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    chk("rst_flush_l4", 32'(c4), 32'd0);
    chk("rst_err_clear", 32'(err1), 32'd0);
    cyc();
    put(1'b0, BASE + 20, 32'd0, 4'h0);
    @(negedge clk);
    chk("rst_mem_kept", rsp1.r_data, 32'h5A5A_A5A5);

    // Counter saturation
    cyc();
    req.req = 1'b1; req.we = 1'b1; req.add = BASE + 32'(4 * NW); req.data = 32'h0; req.be = 4'hF;
    repeat (70000) cyc();
    req = '0;
    @(negedge clk);
    chk("err_sat_l1", 32'(err1), 32'h0000_FFFF);
    chk("err_sat_l4", 32'(err4), 32'h0000_FFFF);
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
